// File: rtl/seg_pkg.sv
// seg_pkg: shared constants, types and the BCD-to-7-segment helper for the
// multiplexed display driver.
//   SEG_0..SEG_9, SEG_BLANK : active-low segment codes, bits 6..0 = g..a
//   SEL_OFF                 : all digit selects released (active-low)
//   disp_data_t             : one complete display image (digits, dp, blank)
//   seg_code()              : nibble to segment code; 10..15 render blank
package seg_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [7:0] SEL_OFF = 8'hff;

    typedef struct packed {
        logic [31:0] digits;
        logic [7:0]  dp_en;
        logic [7:0]  blank_en;
    } disp_data_t;

    // Dark display: every digit force-blanked until the first load arrives.
    localparam disp_data_t DISP_RESET = '{digits: 32'h0, dp_en: 8'h00, blank_en: 8'hff};

    function automatic logic [6:0] seg_code(input logic [3:0] nibble);
        case (nibble)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/seg_scan_drv_if.sv
// seg_scan_drv_if: load bus from the upstream counters into the display driver.
//   din      : 8 BCD nibbles, digit i at din[4i+3:4i], digit 0 rightmost
//   dp_en    : per-digit decimal point enable, 1 = lit
//   blank_en : per-digit force-blank, 1 = all segments off
//   din_vld  : single-cycle strobe capturing din, dp_en and blank_en
// master = data source, slave = display driver.
interface seg_scan_drv_if;
    logic [31:0] din;
    logic [7:0]  dp_en;
    logic [7:0]  blank_en;
    logic        din_vld;

    modport master (output din, dp_en, blank_en, din_vld);
    modport slave  (input  din, dp_en, blank_en, din_vld);
endinterface

// File: rtl/seg_decode.sv
// seg_decode: combinational nibble + dp + blank to active-low segment byte.
//   nibble  : BCD digit, 10..15 shown as blank
//   dp      : 1 = decimal point lit
//   blank   : 1 = whole digit dark regardless of nibble/dp
//   segment : bit7 = dp, bits6..0 = g..a, active-low
module seg_decode
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dp,
    input  logic       blank,
    output logic [7:0] segment
);

    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // so no path through the block can infer a latch.
        segment = 8'hff;
        if (!blank) begin
            segment = {~dp, seg_code(nibble)};
        end
    end

endmodule

// File: rtl/seg_scan_drv.sv
// seg_scan_drv: multiplexed 7-segment driver with anti-ghost blanking and
// frame-synchronous data update.
//   clk, rst_n : clock and synchronous active-low reset
//   bus        : load bus (slave), see seg_scan_drv_if
//   segment    : active-low segments, bit7 = dp, bits6..0 = g..a
//   seg_sel    : active-low one-hot digit select, bits >= DIG_NUM held 1
//   frame_done : one-cycle pulse the cycle after the last slot of a frame
module seg_scan_drv
    import seg_pkg::*;
#(
    parameter int DIG_NUM   = 8,
    parameter int SCAN_CYC  = 50000,
    parameter int BLANK_CYC = 500
) (
    input  logic                 clk,
    input  logic                 rst_n,
    seg_scan_drv_if.slave        bus,
    output logic [7:0]           segment,
    output logic [7:0]           seg_sel,
    output logic                 frame_done
);

    localparam int              CNT_W     = $clog2(SCAN_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYC);
    localparam logic [2:0]       IDX_LAST  = 3'(DIG_NUM - 1);

    logic [CNT_W-1:0] cnt;
    logic [2:0]       idx;
    logic             eof;

    disp_data_t act_data;
    disp_data_t pend_data;
    disp_data_t new_data;
    logic       pending;

    logic [3:0] cur_nibble;
    logic       cur_dp;
    logic       cur_blank;
    logic [7:0] dec_segment;

    assign eof      = (idx == IDX_LAST) && (cnt == CNT_LAST);
    assign new_data = '{digits: bus.din, dp_en: bus.dp_en, blank_en: bus.blank_en};

    // Slot timer and digit index.
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples the pre-edge values of its neighbours.
        if (!rst_n) begin
            cnt <= '0;
            idx <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
            idx <= (idx == IDX_LAST) ? 3'd0 : idx + 3'd1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Double-buffered load: active only changes at the frame boundary, so a
    // frame is always drawn from one consistent image. A strobe landing on
    // the boundary itself bypasses pending and goes straight to active.
    always_ff @(posedge clk) begin
        // NOTE: the data registers are reset on purpose; DISP_RESET keeps the
        // display dark until the first real load instead of showing garbage.
        if (!rst_n) begin
            act_data  <= DISP_RESET;
            pend_data <= DISP_RESET;
            pending   <= 1'b0;
        end else begin
            if (bus.din_vld) begin
                pend_data <= new_data;
            end
            if (eof) begin
                if (bus.din_vld) begin
                    act_data <= new_data;
                end else if (pending) begin
                    act_data <= pend_data;
                end
                pending <= 1'b0;
            end else if (bus.din_vld) begin
                pending <= 1'b1;
            end
        end
    end

    // Single shared decoder fed by the digit currently being scanned.
    assign cur_nibble = act_data.digits[{idx, 2'b00} +: 4];
    assign cur_dp     = act_data.dp_en[idx];
    assign cur_blank  = act_data.blank_en[idx];

    seg_decode u_decode (
        .nibble  (cur_nibble),
        .dp      (cur_dp),
        .blank   (cur_blank),
        .segment (dec_segment)
    );

    // Registered outputs; the first BLANK_CYC cycles of each slot release
    // every select so the previous digit's pattern cannot ghost onto the next.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            segment    <= 8'hff;
            seg_sel    <= SEL_OFF;
            frame_done <= 1'b0;
        end else begin
            frame_done <= eof;
            if (cnt < CNT_BLANK) begin
                segment <= 8'hff;
                seg_sel <= SEL_OFF;
            end else begin
                segment <= dec_segment;
                seg_sel <= ~(8'b1 << idx);
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_drv.sv
// tb_seg_scan_drv: self-checking bench for seg_scan_drv with SCAN_CYC=4,
// BLANK_CYC=1, DIG_NUM=8. A cycle model pushes the expected outputs on each
// rising edge; they are popped and compared on the following falling edge.
// Table vectors and directed sequences add hand-derived expectations.
module tb_seg_scan_drv;

    localparam int SCAN  = 4;
    localparam int BLANK = 1;
    localparam int DIGS  = 8;
    localparam int FRAME = DIGS * SCAN;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] segment;
    logic [7:0] seg_sel;
    logic       frame_done;

    seg_scan_drv_if bus ();

    seg_scan_drv #(
        .DIG_NUM   (DIGS),
        .SCAN_CYC  (SCAN),
        .BLANK_CYC (BLANK)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .segment    (segment),
        .seg_sel    (seg_sel),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, wanted %h", name, act, exp);
        end
    endtask

    // Reference decode written straight from the segment table.
    function automatic logic [7:0] ref_seg(input logic [3:0] n, input logic dp, input logic blk);
        logic [6:0] c;
        case (n)
            4'd0: c = 7'h40;
            4'd1: c = 7'h79;
            4'd2: c = 7'h24;
            4'd3: c = 7'h30;
            4'd4: c = 7'h19;
            4'd5: c = 7'h12;
            4'd6: c = 7'h02;
            4'd7: c = 7'h78;
            4'd8: c = 7'h00;
            4'd9: c = 7'h10;
            default: c = 7'h7f;
        endcase
        return blk ? 8'hff : {~dp, c};
    endfunction

    // ---------------- cycle model + scoreboard ----------------
    typedef struct packed {
        logic [7:0] seg;
        logic [7:0] sel;
        logic       fd;
    } exp_t;

    exp_t exp_q[$];

    int          m_cyc  = 0;        // position in frame: idx*SCAN + cnt
    logic [31:0] m_din  = 32'h0;
    logic [7:0]  m_dp   = 8'h00;
    logic [7:0]  m_bl   = 8'hff;
    logic [31:0] p_din  = 32'h0;
    logic [7:0]  p_dp   = 8'h00;
    logic [7:0]  p_bl   = 8'hff;
    logic        m_pend = 1'b0;

    function automatic exp_t model_out();
        exp_t r;
        int   i;
        int   c;
        i = m_cyc / SCAN;
        c = m_cyc % SCAN;
        if (!rst_n) begin
            r = '{seg: 8'hff, sel: 8'hff, fd: 1'b0};
        end else begin
            r.fd = (m_cyc == FRAME - 1);
            if (c < BLANK) begin
                r.seg = 8'hff;
                r.sel = 8'hff;
            end else begin
                r.sel = ~(8'h01 << i);
                r.seg = ref_seg(m_din[i*4 +: 4], m_dp[i], m_bl[i]);
            end
        end
        return r;
    endfunction

    always @(posedge clk) begin
        exp_q.push_back(model_out());
        if (!rst_n) begin
            m_cyc  <= 0;
            m_din  <= 32'h0;
            m_dp   <= 8'h00;
            m_bl   <= 8'hff;
            m_pend <= 1'b0;
        end else begin
            m_cyc <= (m_cyc == FRAME - 1) ? 0 : m_cyc + 1;
            if (m_cyc == FRAME - 1) begin
                if (bus.din_vld) begin
                    m_din <= bus.din;
                    m_dp  <= bus.dp_en;
                    m_bl  <= bus.blank_en;
                end else if (m_pend) begin
                    m_din <= p_din;
                    m_dp  <= p_dp;
                    m_bl  <= p_bl;
                end
                m_pend <= 1'b0;
            end else if (bus.din_vld) begin
                p_din  <= bus.din;
                p_dp   <= bus.dp_en;
                p_bl   <= bus.blank_en;
                m_pend <= 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            check("sb_segment", segment, exp_q[0].seg);
            check("sb_seg_sel", seg_sel, exp_q[0].sel);
            check("sb_frame_done", {7'b0, frame_done}, {7'b0, exp_q[0].fd});
            void'(exp_q.pop_front());
        end
    end

    // ---------------- helpers ----------------
    // Returns at the falling edge where the scan state is (idx, cnt).
    task automatic wait_state(input int idx, input int cnt);
        for (int n = 0; n < 4 * FRAME; n++) begin
            @(negedge clk);
            if (m_cyc == idx * SCAN + cnt) return;
        end
        total++;
        bad++;
        $display("FAIL wait_state(%0d,%0d): state never reached", idx, cnt);
    endtask

    // Outputs currently show the first lit cycle of digit d.
    task automatic show(input int d);
        wait_state(d, BLANK + 1);
    endtask

    task automatic pulse(input logic [31:0] d, input logic [7:0] dp, input logic [7:0] bl);
        bus.din      = d;
        bus.dp_en    = dp;
        bus.blank_en = bl;
        bus.din_vld  = 1'b1;
        @(negedge clk);
        bus.din_vld  = 1'b0;
    endtask

    typedef struct {
        logic [31:0] din;
        logic [7:0]  dp;
        logic [7:0]  bl;
        int          dig;
        logic [7:0]  seg;
        logic [7:0]  sel;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int n;

        vecs[0] = '{32'h76543210, 8'h04, 8'h00, 0, 8'hc0, 8'hfe};
        vecs[1] = '{32'h76543210, 8'h04, 8'h00, 2, 8'h24, 8'hfb};
        vecs[2] = '{32'h76543210, 8'h04, 8'h00, 7, 8'hf8, 8'h7f};
        vecs[3] = '{32'h0000a000, 8'h00, 8'h20, 3, 8'hff, 8'hf7};
        vecs[4] = '{32'h0000a000, 8'h00, 8'h20, 5, 8'hff, 8'hdf};
        vecs[5] = '{32'h00000008, 8'h01, 8'h00, 0, 8'h00, 8'hfe};
        vecs[6] = '{32'h98765432, 8'h00, 8'h00, 1, 8'hb0, 8'hfd};
        vecs[7] = '{32'h98765432, 8'h80, 8'h00, 7, 8'h10, 8'h7f};

        bus.din      = 32'h0;
        bus.dp_en    = 8'h00;
        bus.blank_en = 8'h00;
        bus.din_vld  = 1'b0;

        // Reset state.
        repeat (3) @(negedge clk);
        check("reset_segment", segment, 8'hff);
        check("reset_seg_sel", seg_sel, 8'hff);
        check("reset_frame_done", {7'b0, frame_done}, 8'h00);
        rst_n = 1'b1;

        // Scenario 1: first frame_done after 32 rising edges (33rd cycle
        // counting the release cycle as 1), then every 32.
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!frame_done && n < 100);
        check("first_frame_done_cycles", 8'(n), 8'd32);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!frame_done && n < 100);
        check("frame_done_period", 8'(n), 8'd32);
        show(4);
        check("idle_dark_segment", segment, 8'hff);
        check("idle_seg_sel", seg_sel, 8'hef);

        // Scenario 2: mid-frame load is invisible until the frame boundary.
        wait_state(2, 0);
        pulse(32'h76543210, 8'h04, 8'h00);
        show(5);
        check("no_tear_segment", segment, 8'hff);
        wait_state(DIGS - 1, SCAN - 1);
        show(0);
        check("s2_digit0", segment, 8'hc0);
        show(2);
        check("s2_digit2_dp", segment, 8'h24);
        show(7);
        check("s2_digit7", segment, 8'hf8);

        // Table vectors: load mid-frame, inspect one digit in the next frame.
        foreach (vecs[i]) begin
            wait_state(2, 0);
            pulse(vecs[i].din, vecs[i].dp, vecs[i].bl);
            wait_state(DIGS - 1, SCAN - 1);
            show(vecs[i].dig);
            check($sformatf("vec%0d_segment", i), segment, vecs[i].seg);
            check($sformatf("vec%0d_seg_sel", i), seg_sel, vecs[i].sel);
        end

        // Scenario 4: two loads in one frame, the last wins.
        wait_state(1, 0);
        pulse(32'h11111111, 8'h00, 8'h00);
        wait_state(3, 0);
        pulse(32'h22222222, 8'h00, 8'h00);
        wait_state(DIGS - 1, SCAN - 1);
        show(1);
        check("s4_digit1", segment, 8'ha4);
        show(6);
        check("s4_digit6", segment, 8'ha4);

        // Scenario 3: load on the EOF cycle goes straight to active.
        wait_state(DIGS - 1, SCAN - 1);
        pulse(32'h99999999, 8'h00, 8'h00);
        show(0);
        check("s3_digit0", segment, 8'h90);
        show(7);
        check("s3_digit7", segment, 8'h90);
        wait_state(DIGS - 1, SCAN - 1);
        show(4);
        check("s3_no_stale_pending", segment, 8'h90);

        // Scenario 6: one-cycle reset while digit 5 is shown drops pending data.
        wait_state(5, 1);
        pulse(32'h33333333, 8'h00, 8'h00);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("s6_reset_segment", segment, 8'hff);
        check("s6_reset_seg_sel", seg_sel, 8'hff);
        check("s6_reset_frame_done", {7'b0, frame_done}, 8'h00);
        show(0);
        check("s6_restart_seg_sel", seg_sel, 8'hfe);
        check("s6_cleared_segment", segment, 8'hff);
        wait_state(DIGS - 1, SCAN - 1);
        show(3);
        check("s6_pending_dropped", segment, 8'hff);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
